backup_arbiter: RTL and testbench
=================================

BACKUP_ARBITER -- requirements
Module: backup_arbiter

Interface
REQ-001 SHALL have parameter K, default 10: number of IC register wrappers (requesters).
REQ-002 SHALL have parameter N, default 32: value width per wrapper.
REQ-003 SHALL have parameter DEPTH, default 4: queue entries, power of two >= 2; LOG2_K = $clog2(K).
REQ-004 SHALL have port Clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port Rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port Pwr_off, input, 1: power-down, freezes admission.
REQ-007 SHALL have port Req, input, K: per-wrapper backup request, level.
REQ-008 SHALL have port ReqVals, input, K*N: wrapper i value at bits [i*N+N-1 : i*N].
REQ-009 SHALL have port Gnt, output, K: one-hot grant, combinational.
REQ-010 SHALL have port PullEn, input, 1: consumer pop strobe.
REQ-011 SHALL have port IsEmpty, output, 1: queue empty.
REQ-012 SHALL have port IsFull, output, 1: queue holds DEPTH entries.
REQ-013 SHALL have port ValBuffer, output, N: head entry value.
REQ-014 SHALL have port AddrBuffer, output, LOG2_K: head entry wrapper index.
REQ-015 SHALL have port Start, output, 1: one-cycle kick to the consumer FSM.

Function
REQ-016 SHALL grant at most one requester per cycle, and only when Rst=1, Pwr_off=0 and IsFull=0.
REQ-017 SHALL pick the winner as the first index i with Req[i]=1, scanning from rr_ptr upward and wrapping K-1 -> 0.
REQ-018 SHALL assert Gnt[winner] in the same cycle, and SHALL push {winner, ReqVals[winner]} into the tail on that rising edge.
REQ-019 SHALL set rr_ptr to (winner+1) mod K on each grant; with no grant, rr_ptr holds.
REQ-020 SHALL present the head entry first-word fall-through on ValBuffer/AddrBuffer; both SHALL read 0 when empty.
REQ-021 SHALL pop the head on an edge where PullEn=1 and IsEmpty=0; PullEn while empty SHALL be ignored without underflow.
REQ-022 SHALL leave occupancy unchanged on a simultaneous push and pop; a pop SHALL NOT enable a grant in the same cycle that starts full.
REQ-023 SHALL keep occupancy in 0..DEPTH, with read/write pointers wrapping modulo DEPTH.
REQ-024 SHALL register Start high for exactly one cycle after an edge where occupancy goes 0 -> 1; it SHALL be 0 otherwise and while Pwr_off=1.
REQ-025 SHALL, while Pwr_off=1, force Gnt=0 and block pushes; pops still proceed and queue contents are retained.
REQ-026 SHALL accept that a requester holding Req after Gnt is re-arbitrated as a new request (requester drops Req on Gnt).

Reset
REQ-027 SHALL, on Rst=0 (async): occupancy 0, pointers 0, rr_ptr 0, IsEmpty=1, IsFull=0, Gnt=0, Start=0, ValBuffer=0, AddrBuffer=0.
REQ-028 SHALL discard pending entries on reset mid-operation, and SHALL not grant before the first edge after Rst rises.

Configuration
REQ-029 SHALL, with BACKUP_ARB_STATUS_EN defined, add output Count ($clog2(DEPTH+1) bits, current occupancy, reset 0).
REQ-030 SHALL, with BACKUP_ARB_STATUS_EN defined, add output Overflow (1 bit, sticky): set on any edge with |Req=1, IsFull=1, Pwr_off=0, and cleared only by reset.
REQ-031 SHALL, without BACKUP_ARB_STATUS_EN, omit Count and Overflow, with all other behaviour identical.

Verification
REQ-032 SHALL cover: K=10, Req=0x201 (wrappers 0, 9) held, rr_ptr=0 -> Gnt=0x001, then after drop Gnt=0x200; AddrBuffer head 0 then 9; Start pulses once.
REQ-033 SHALL cover: DEPTH=4, Req=0x3FF held, no PullEn -> grants 0,1,2,3, then IsFull=1, Gnt=0 (Overflow=1 if enabled).
REQ-034 SHALL cover: full queue, PullEn=1 one cycle -> AddrBuffer advances 0 -> 1, IsFull=0, grant to 4 on next cycle.
REQ-035 SHALL cover: 1 entry, push and PullEn same edge -> occupancy stays 1, head = new entry, no Start.
REQ-036 SHALL cover: Pwr_off=1 with 2 entries, Req=0x3FF -> Gnt=0; two PullEn -> IsEmpty=1, ValBuffer=0, Start=0.
REQ-037 SHALL cover: Rst=0 mid-stream at 3 entries -> IsEmpty=1, Gnt=0, Start=0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/backup_arbiter_if.sv
// Request/grant and queue-status bundle between the wrappers, the backup arbiter and its consumer.
// BACKUP_ARB_STATUS_EN adds the Count and Overflow status signals.
interface backup_arbiter_if #(
    parameter int K     = 10,
    parameter int N     = 32,
    parameter int DEPTH = 4
);
    localparam int LOG2_K = $clog2(K);
    localparam int CW     = $clog2(DEPTH + 1);

    logic              Pwr_off;
    logic [K-1:0]      Req;
    logic [K*N-1:0]    ReqVals;
    logic [K-1:0]      Gnt;
    logic              PullEn;
    logic              IsEmpty;
    logic              IsFull;
    logic [N-1:0]      ValBuffer;
    logic [LOG2_K-1:0] AddrBuffer;
    logic              Start;

`ifdef BACKUP_ARB_STATUS_EN
    logic [CW-1:0]     Count;
    logic              Overflow;

    modport slave (
        input  Pwr_off, Req, ReqVals, PullEn,
        output Gnt, IsEmpty, IsFull, ValBuffer, AddrBuffer, Start, Count, Overflow
    );
    modport master (
        output Pwr_off, Req, ReqVals, PullEn,
        input  Gnt, IsEmpty, IsFull, ValBuffer, AddrBuffer, Start, Count, Overflow
    );
`else
    modport slave (
        input  Pwr_off, Req, ReqVals, PullEn,
        output Gnt, IsEmpty, IsFull, ValBuffer, AddrBuffer, Start
    );
    modport master (
        output Pwr_off, Req, ReqVals, PullEn,
        input  Gnt, IsEmpty, IsFull, ValBuffer, AddrBuffer, Start
    );
`endif
endinterface

// File: rtl/backup_arbiter.sv
// Round-robin arbiter over K register wrappers feeding a DEPTH-entry FWFT queue of {index, value}.
// Define BACKUP_ARB_STATUS_EN to add the Count and sticky Overflow status outputs.
module backup_arbiter #(
    parameter int K     = 10,
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input logic             Clk,
    input logic             Rst,
    backup_arbiter_if.slave bus
);
    localparam int LOG2_K = $clog2(K);
    localparam int LOG2_D = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [LOG2_K-1:0] addr;
        logic [N-1:0]      val;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [LOG2_D-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [LOG2_K-1:0] rr_ptr, winner;
    logic [N-1:0]      win_val;
    logic [K-1:0]      gnt;
    logic              found, push, pop, full, empty, start_q;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Rotating scan: offset 0 is rr_ptr, wrapping past K-1 back to 0.
    always_comb begin
        int unsigned       idx;
        logic [LOG2_K-1:0] idx_k;
        idx    = 0;
        idx_k  = '0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned off = 0; off < K; off++) begin
            idx = 32'(rr_ptr) + off;
            if (idx >= K) idx = idx - K;
            idx_k = LOG2_K'(idx);
            if (!found && bus.Req[idx_k]) begin
                found  = 1'b1;
                winner = idx_k;
            end
        end
    end

    always_comb begin
        win_val = '0;
        for (int unsigned i = 0; i < K; i++) begin
            if (LOG2_K'(i) == winner) win_val = bus.ReqVals[i*N +: N];
        end
    end

    // full is the start-of-cycle occupancy, so a same-cycle pop never opens a grant.
    assign push = Rst && !bus.Pwr_off && !full && found;
    assign pop  = bus.PullEn && !empty;

    always_comb begin
        gnt = '0;
        if (push) gnt[winner] = 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rr_ptr  <= '0;
            start_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push) rr_ptr <= (winner == LOG2_K'(K - 1)) ? '0 : winner + 1'b1;
            start_q <= push && empty;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= '{addr: winner, val: win_val};
    end

    assign head           = mem[rd_ptr];
    assign bus.Gnt        = gnt;
    assign bus.IsEmpty    = empty;
    assign bus.IsFull     = full;
    assign bus.ValBuffer  = empty ? '0 : head.val;
    assign bus.AddrBuffer = empty ? '0 : head.addr;
    assign bus.Start      = start_q && !bus.Pwr_off;

`ifdef BACKUP_ARB_STATUS_EN
    logic overflow;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)                                   overflow <= 1'b0;
        else if (|bus.Req && full && !bus.Pwr_off)  overflow <= 1'b1;
    end

    assign bus.Count    = count;
    assign bus.Overflow = overflow;
`endif
endmodule

// File: tb/tb_backup_arbiter.sv
// Bench for backup_arbiter: directed vector table plus randomized traffic against a queue-based model.
module tb_backup_arbiter;
    localparam int K      = 10;
    localparam int N      = 32;
    localparam int DEPTH  = 4;
    localparam int LOG2_K = $clog2(K);
    localparam logic [N-1:0] VAL_BASE = 32'hA500_0000;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    backup_arbiter_if #(.K(K), .N(N), .DEPTH(DEPTH)) bus ();
    backup_arbiter #(.K(K), .N(N), .DEPTH(DEPTH)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [LOG2_K-1:0] addr;
        logic [N-1:0]      val;
    } entry_t;

    entry_t mq [$];
    int     m_rr;
    bit     m_start;
    bit     m_ovf;

    typedef struct {
        logic [K-1:0] req;
        bit           pull;
        bit           pwr;
        logic [K-1:0] gnt;
        int           addr;
        bit           empty;
        bit           full;
        bit           start;
    } vec_t;

    vec_t tbl [$];

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int m_winner(logic [K-1:0] r);
        for (int i = 0; i < K; i++) begin
            int j;
            j = (m_rr + i) % K;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_rr    = 0;
        m_start = 0;
        m_ovf   = 0;
    endtask

    // Applied at each rising edge with the inputs that were stable during the cycle.
    task automatic model_edge();
        int  w, old;
        bit  g, full;
        if (!Rst) begin
            model_reset();
            return;
        end
        full = (mq.size() == DEPTH);
        w    = m_winner(bus.Req);
        g    = !bus.Pwr_off && !full && (w >= 0);
        old  = mq.size();
        if (|bus.Req && full && !bus.Pwr_off) m_ovf = 1;
        if (bus.PullEn && old > 0) void'(mq.pop_front());
        if (g) begin
            mq.push_back('{addr: LOG2_K'(w), val: bus.ReqVals[w*N +: N]});
            m_rr = (w + 1) % K;
        end
        m_start = (old == 0 && mq.size() == 1);
    endtask

    task automatic model_check(string tag);
        int           w;
        logic [K-1:0] eg;
        bit           empty;
        eg    = '0;
        w     = m_winner(bus.Req);
        empty = (mq.size() == 0);
        if (Rst && !bus.Pwr_off && mq.size() < DEPTH && w >= 0) eg[w] = 1'b1;
        check($sformatf("%s.gnt", tag), bus.Gnt, eg);
        check($sformatf("%s.empty", tag), bus.IsEmpty, empty);
        check($sformatf("%s.full", tag), bus.IsFull, mq.size() == DEPTH);
        check($sformatf("%s.val", tag), bus.ValBuffer, empty ? '0 : mq[0].val);
        check($sformatf("%s.addr", tag), bus.AddrBuffer, empty ? '0 : mq[0].addr);
        check($sformatf("%s.start", tag), bus.Start, m_start && !bus.Pwr_off && Rst);
`ifdef BACKUP_ARB_STATUS_EN
        check($sformatf("%s.count", tag), bus.Count, mq.size());
        check($sformatf("%s.ovf", tag), bus.Overflow, m_ovf);
`endif
    endtask

    task automatic add(logic [K-1:0] req, bit pull, bit pwr, logic [K-1:0] gnt,
                       int addr, bit empty, bit full, bit start);
        tbl.push_back('{req: req, pull: pull, pwr: pwr, gnt: gnt, addr: addr,
                        empty: empty, full: full, start: start});
    endtask

    initial begin
        bus.Pwr_off = 1'b0;
        bus.Req     = '0;
        bus.PullEn  = 1'b0;
        for (int i = 0; i < K; i++) bus.ReqVals[i*N +: N] = VAL_BASE + N'(i);
        model_reset();

        // Two-requester round robin, Start once, drain
        add(10'h201, 0, 0, 10'h001, 0, 1, 0, 0);
        add(10'h200, 0, 0, 10'h200, 0, 0, 0, 1);
        add(10'h000, 1, 0, 10'h000, 0, 0, 0, 0);
        add(10'h000, 1, 0, 10'h000, 9, 0, 0, 0);
        add(10'h000, 0, 0, 10'h000, 0, 1, 0, 0);
        // Fill to DEPTH, then blocked while full
        add(10'h3FF, 0, 0, 10'h001, 0, 1, 0, 0);
        add(10'h3FF, 0, 0, 10'h002, 0, 0, 0, 1);
        add(10'h3FF, 0, 0, 10'h004, 0, 0, 0, 0);
        add(10'h3FF, 0, 0, 10'h008, 0, 0, 0, 0);
        add(10'h3FF, 0, 0, 10'h000, 0, 0, 1, 0);
        // Pop from full: no grant this cycle, grant to 4 the next
        add(10'h3FF, 1, 0, 10'h000, 0, 0, 1, 0);
        add(10'h3FF, 0, 0, 10'h010, 1, 0, 0, 0);
        add(10'h000, 1, 0, 10'h000, 1, 0, 1, 0);
        add(10'h000, 1, 0, 10'h000, 2, 0, 0, 0);
        add(10'h000, 1, 0, 10'h000, 3, 0, 0, 0);
        add(10'h000, 1, 0, 10'h000, 4, 0, 0, 0);
        add(10'h000, 0, 0, 10'h000, 0, 1, 0, 0);
        // One entry, push and pop on the same edge: no second Start
        add(10'h020, 0, 0, 10'h020, 0, 1, 0, 0);
        add(10'h040, 1, 0, 10'h040, 5, 0, 0, 1);
        add(10'h000, 0, 0, 10'h000, 6, 0, 0, 0);
        add(10'h080, 0, 0, 10'h080, 6, 0, 0, 0);
        // Power-off with two entries: pops proceed, no grants, PullEn while empty ignored
        add(10'h3FF, 1, 1, 10'h000, 6, 0, 0, 0);
        add(10'h3FF, 1, 1, 10'h000, 7, 0, 0, 0);
        add(10'h3FF, 1, 1, 10'h000, 0, 1, 0, 0);
        add(10'h3FF, 0, 1, 10'h000, 0, 1, 0, 0);
        // Build three entries ahead of the mid-stream reset
        add(10'h100, 0, 0, 10'h100, 0, 1, 0, 0);
        add(10'h200, 0, 0, 10'h200, 8, 0, 0, 1);
        add(10'h001, 0, 0, 10'h001, 8, 0, 0, 0);

        // Reset state, with every requester asserting
        @(negedge Clk);
        bus.Req = '1;
        #1;
        check("rst.gnt", bus.Gnt, '0);
        check("rst.empty", bus.IsEmpty, 1'b1);
        check("rst.full", bus.IsFull, 1'b0);
        check("rst.start", bus.Start, 1'b0);
        check("rst.val", bus.ValBuffer, '0);
        check("rst.addr", bus.AddrBuffer, '0);
        @(negedge Clk);
        Rst = 1'b1;

        foreach (tbl[r]) begin
            bus.Req     = tbl[r].req;
            bus.PullEn  = tbl[r].pull;
            bus.Pwr_off = tbl[r].pwr;
            #1;
            check($sformatf("v%0d.gnt", r), bus.Gnt, tbl[r].gnt);
            check($sformatf("v%0d.addr", r), bus.AddrBuffer, tbl[r].addr);
            check($sformatf("v%0d.val", r), bus.ValBuffer,
                  tbl[r].empty ? '0 : VAL_BASE + N'(tbl[r].addr));
            check($sformatf("v%0d.empty", r), bus.IsEmpty, tbl[r].empty);
            check($sformatf("v%0d.full", r), bus.IsFull, tbl[r].full);
            check($sformatf("v%0d.start", r), bus.Start, tbl[r].start);
            @(posedge Clk);
            model_edge();
            @(negedge Clk);
        end

`ifdef BACKUP_ARB_STATUS_EN
        check("pre_rst.count", bus.Count, 3);
        check("pre_rst.ovf", bus.Overflow, 1'b1);
`endif

        // Asynchronous reset mid-stream at three entries, observed before any edge
        bus.Req    = '1;
        bus.PullEn = 1'b0;
        #3;
        Rst = 1'b0;
        model_reset();
        #1;
        check("async.empty", bus.IsEmpty, 1'b1);
        check("async.gnt", bus.Gnt, '0);
        check("async.start", bus.Start, 1'b0);
        check("async.full", bus.IsFull, 1'b0);
        check("async.val", bus.ValBuffer, '0);
        check("async.addr", bus.AddrBuffer, '0);
`ifdef BACKUP_ARB_STATUS_EN
        check("async.count", bus.Count, 0);
        check("async.ovf", bus.Overflow, 1'b0);
`endif
        @(negedge Clk);
        Rst = 1'b1;

        for (int c = 0; c < 600; c++) begin
            bus.Req = K'($urandom);
            if ($urandom_range(0, 3) == 0) bus.Req = '0;
            else if ($urandom_range(0, 2) == 0) bus.Req = K'(1) << $urandom_range(0, K - 1);
            bus.PullEn  = ($urandom_range(0, 2) == 0);
            bus.Pwr_off = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < K; i++) bus.ReqVals[i*N +: N] = $urandom;
            #1;
            model_check($sformatf("r%0d", c));
            if (c == 300) begin
                #1;
                Rst = 1'b0;
                model_reset();
                #1;
                model_check($sformatf("r%0d.rst", c));
            end
            @(posedge Clk);
            model_edge();
            @(negedge Clk);
            Rst = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
